// File: rtl/matmul_sched.sv
// matmul_sched: sequences operand loads, MAC dot products and result writes
// for an n x n matrix multiply held in MAX_N-pitched buffers.
module matmul_sched #(
    parameter int MAX_N = 6,
    parameter int WAIT_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] sizes,
    output logic       ren,
    output logic       raddr,
    output logic       load_we,
    output logic [5:0] load_addr,
    output logic [5:0] rd_addr_a,
    output logic [5:0] rd_addr_b,
    output logic       mac_clr,
    output logic       mac_en,
    output logic       mac_last,
    output logic       wen,
    output logic [5:0] waddr,
    output logic       finish,
    output logic       err,
    output logic [4:0] state,
    output logic [8:0] input_data_num,
    output logic [8:0] out_data_num
);
    typedef enum logic [4:0] {
        IDLE   = 5'd0,
        LOAD_A = 5'd1,
        LOAD_B = 5'd2,
        COMP   = 5'd3,
        WAIT   = 5'd4,
        WRITE  = 5'd5,
        DONE   = 5'd6
    } st_t;
    st_t st;
    logic       start_q;
    logic [3:0] n, i, j, k, col, ni, nj;
    logic [7:0] cnt, w, nn;
    logic       ld_last, row_end, el_last;
    logic [5:0] step, wr_addr;
    assign state   = st;
    assign nn      = 8'(n) * 8'(n);
    assign ld_last = cnt == nn - 8'd1;
    assign row_end = col == n - 4'd1;
    // end of a row jumps over the unused tail of the MAX_N-wide buffer row
    assign step    = row_end ? 6'(MAX_N) - 6'(n) + 6'd1 : 6'd1;
    assign el_last = i == n - 4'd1 && j == n - 4'd1;
    assign ni      = j == n - 4'd1 ? i + 4'd1 : i;
    assign nj      = j == n - 4'd1 ? 4'd0 : j + 4'd1;
    assign wr_addr = 6'(i) * 6'(MAX_N) + 6'(j);
    always_ff @(posedge clk) begin
        if (rst) begin
            st             <= IDLE;
            start_q        <= 1'b0;
            n              <= '0;
            i              <= '0;
            j              <= '0;
            k              <= '0;
            col            <= '0;
            cnt            <= '0;
            w              <= '0;
            ren            <= 1'b0;
            raddr          <= 1'b0;
            load_we        <= 1'b0;
            load_addr      <= '0;
            rd_addr_a      <= '0;
            rd_addr_b      <= '0;
            mac_clr        <= 1'b0;
            mac_en         <= 1'b0;
            mac_last       <= 1'b0;
            wen            <= 1'b0;
            waddr          <= '0;
            finish         <= 1'b0;
            err            <= 1'b0;
            input_data_num <= '0;
            out_data_num   <= '0;
        end else begin
            start_q  <= start;
            mac_clr  <= 1'b0;
            mac_en   <= 1'b0;
            mac_last <= 1'b0;
            wen      <= 1'b0;
            finish   <= 1'b0;
            case (st)
                IDLE: if (start && !start_q) begin
                    if (sizes == 4'd0 || int'(sizes) > MAX_N) begin
                        st     <= DONE;
                        err    <= 1'b1;
                        finish <= 1'b1;
                    end else begin
                        st             <= LOAD_A;
                        n              <= sizes;
                        err            <= 1'b0;
                        input_data_num <= '0;
                        out_data_num   <= '0;
                        cnt            <= '0;
                        col            <= '0;
                        ren            <= 1'b1;
                        load_we        <= 1'b1;
                        raddr          <= 1'b0;
                        load_addr      <= '0;
                    end
                end
                LOAD_A, LOAD_B: begin
                    input_data_num <= input_data_num + 9'd1;
                    cnt            <= ld_last ? 8'd0 : cnt + 8'd1;
                    col            <= row_end ? 4'd0 : col + 4'd1;
                    load_addr      <= ld_last ? 6'd0 : load_addr + step;
                    if (ld_last && st == LOAD_A) begin
                        st    <= LOAD_B;
                        raddr <= 1'b1;
                    end
                    if (ld_last && st == LOAD_B) begin
                        st        <= COMP;
                        ren       <= 1'b0;
                        load_we   <= 1'b0;
                        raddr     <= 1'b0;
                        i         <= '0;
                        j         <= '0;
                        k         <= '0;
                        rd_addr_a <= '0;
                        rd_addr_b <= '0;
                        mac_clr   <= 1'b1;
                        mac_en    <= 1'b1;
                        mac_last  <= n == 4'd1;
                    end
                end
                COMP: if (k == n - 4'd1) begin
                    w <= '0;
                    if (WAIT_CYC == 0) begin
                        st    <= WRITE;
                        wen   <= 1'b1;
                        waddr <= wr_addr;
                    end else begin
                        st <= WAIT;
                    end
                end else begin
                    k         <= k + 4'd1;
                    mac_en    <= 1'b1;
                    mac_last  <= k + 4'd2 == n;
                    rd_addr_a <= rd_addr_a + 6'd1;
                    rd_addr_b <= rd_addr_b + 6'(MAX_N);
                end
                WAIT: if (w == 8'(WAIT_CYC - 1)) begin
                    st    <= WRITE;
                    wen   <= 1'b1;
                    waddr <= wr_addr;
                end else begin
                    w <= w + 8'd1;
                end
                WRITE: begin
                    out_data_num <= out_data_num + 9'd1;
                    if (el_last) begin
                        st     <= DONE;
                        finish <= 1'b1;
                    end else begin
                        st        <= COMP;
                        i         <= ni;
                        j         <= nj;
                        k         <= '0;
                        rd_addr_a <= 6'(ni) * 6'(MAX_N);
                        rd_addr_b <= 6'(nj);
                        mac_clr   <= 1'b1;
                        mac_en    <= 1'b1;
                        mac_last  <= n == 4'd1;
                    end
                end
                DONE: begin
                    st        <= IDLE;
                    raddr     <= 1'b0;
                    load_addr <= '0;
                    rd_addr_a <= '0;
                    rd_addr_b <= '0;
                    waddr     <= '0;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_sched.sv
// tb_matmul_sched: directed checks of load/compute/write sequencing, latency,
// invalid sizes, mid-job reset and start-edge handling.
module tb_matmul_sched;
    localparam int M = 6, W = 2;
    logic clk = 0, rst = 1, start = 0;
    logic [3:0] sizes = 0;
    logic ren, raddr, load_we, mac_clr, mac_en, mac_last, wen, finish, err;
    logic [5:0] load_addr, rd_addr_a, rd_addr_b, waddr;
    logic [4:0] state;
    logic [8:0] input_data_num, out_data_num;
    logic [51:0] all_out;
    int tests = 0, fails = 0;
    int fin_cyc, ren_cnt, addr_bad, strobe_bad, mac_cnt, clr_last, bad, wait_cnt;
    int wq[$], bq[$];

    always #5 clk = ~clk;

    assign all_out = {ren, raddr, load_we, load_addr, rd_addr_a, rd_addr_b, mac_clr, mac_en,
                      mac_last, wen, waddr, finish, err, input_data_num, out_data_num};

    matmul_sched dut (
        .clk(clk), .rst(rst), .start(start), .sizes(sizes), .ren(ren), .raddr(raddr),
        .load_we(load_we), .load_addr(load_addr), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_last(mac_last), .wen(wen), .waddr(waddr),
        .finish(finish), .err(err), .state(state), .input_data_num(input_data_num),
        .out_data_num(out_data_num)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start edge is sampled by the first posedge; cycle c is the c-th period after it.
    task automatic run(input int nsz, input bit hold);
        int nn;
        nn = nsz * nsz;
        fin_cyc = -1; ren_cnt = 0; addr_bad = 0; strobe_bad = 0; mac_cnt = 0; clr_last = 0;
        wq.delete(); bq.delete();
        sizes = 4'(nsz);
        start = 1;
        @(posedge clk);
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            start = hold;
            if (ren) begin
                int e;
                e = ren_cnt % nn;
                if (raddr !== (ren_cnt >= nn) || load_addr !== 6'((e / nsz) * M + e % nsz) || load_we !== 1'b1)
                    addr_bad++;
                ren_cnt++;
            end
            if (((ren || load_we) && state != 1 && state != 2) ||
                ((mac_en || mac_clr || mac_last) && state != 3) ||
                (wen && state != 5) || (finish && state != 6))
                strobe_bad++;
            if (mac_en) begin
                mac_cnt++;
                if (mac_clr && mac_last) clr_last++;
                if (wq.size() == nn - 1) bq.push_back(int'(rd_addr_b));
            end
            if (wen) wq.push_back(int'(waddr));
            if (finish) begin
                fin_cyc = c;
                break;
            end
        end
        chk("finish_cycle", fin_cyc, 2 * nn + nn * (nsz + 1 + W) + 1);
        chk("ren_cycles", ren_cnt, 2 * nn);
        chk("load_addr_raddr", addr_bad, 0);
        chk("strobes_outside_state", strobe_bad, 0);
        chk("mac_en_cycles", mac_cnt, nn * nsz);
        chk("clr_last_coincide", clr_last, nsz == 1 ? 1 : 0);
        chk("wen_count", wq.size(), nn);
        bad = 0;
        for (int x = 0; x < wq.size() && x < nn; x++)
            if (wq[x] != (x / nsz) * M + x % nsz) bad++;
        chk("waddr_seq", bad, 0);
        chk("input_data_num", input_data_num, 2 * nn);
        chk("out_data_num", out_data_num, nn);
        chk("err_clear", err, 0);
        @(negedge clk);
        start = hold;
        chk("idle_after_done", state, 0);
    endtask

    task automatic err_job(input int sz);
        sizes = 4'(sz);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("err_state_done", state, 6);
        chk("err_finish", finish, 1);
        chk("err_flag", err, 1);
        chk("err_no_ren", ren, 0);
        @(negedge clk);
        chk("err_state_idle", state, 0);
        chk("err_held", err, 1);
        chk("err_no_ren_idle", ren, 0);
    endtask

    initial begin
        rst = 1;
        repeat (2) @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_outputs", all_out, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_no_start", state, 0);

        run(2, 0);
        run(1, 0);
        run(6, 0);
        chk("last_elem_rd_b_count", bq.size(), 6);
        bad = 0;
        for (int x = 0; x < bq.size() && x < 6; x++)
            if (bq[x] != x * M + 5) bad++;
        chk("last_elem_rd_b_seq", bad, 0);

        err_job(0);
        err_job(7);

        sizes = 3;
        start = 1;
        wait_cnt = 0;
        while (state !== 5'd3 && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("reach_comp", state, 3);
        rst = 1;
        @(negedge clk);
        chk("midjob_rst_state", state, 0);
        chk("midjob_rst_outputs", all_out, 0);
        rst = 0;
        run(3, 1);

        start = 0;
        @(negedge clk);
        run(1, 1);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (state !== 5'd0 || ren !== 1'b0) bad++;
        end
        chk("held_start_no_relaunch", bad, 0);
        start = 0;
        @(negedge clk);
        run(1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/matmul_sched.md
MATMUL_SCHED -- requirements
Module: matmul_sched

Interface
REQ-001 Parameter MAX_N, default 6: maximum matrix dimension and the row pitch of the operand/result buffers.
REQ-002 Parameter WAIT_CYC, default 2: datapath MAC pipeline latency, in cycles, from the last mac_en to a valid result.
REQ-003 clk  in  1  rising-edge clock for all logic.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  job request; a rising edge is sampled in IDLE.
REQ-006 sizes  in  4  matrix dimension n, latched at job start.
REQ-007 ren  out  1  source read enable; rdata is valid in the same cycle.
REQ-008 raddr  out  1  source select: 0 = matrix A, 1 = matrix B.
REQ-009 load_we  out  1  operand buffer write strobe.
REQ-010 load_addr  out  6  operand buffer address, row*MAX_N+col.
REQ-011 rd_addr_a, rd_addr_b  out  6 each  operand read addresses to the MAC.
REQ-012 mac_clr  out  1  clear the accumulator and load the first product.
REQ-013 mac_en  out  1  accumulate enable.
REQ-014 mac_last  out  1  marks the final product of a dot product.
REQ-015 wen  out  1  result write strobe.
REQ-016 waddr  out  6  result address, i*MAX_N+j.
REQ-017 finish  out  1  one-cycle job-complete pulse.
REQ-018 err  out  1  invalid-size flag.
REQ-019 state  out  5  FSM state code.
REQ-020 input_data_num  out  9  count of loaded elements.
REQ-021 out_data_num  out  9  count of written results.

Function
REQ-022 State codes: IDLE=0, LOAD_A=1, LOAD_B=2, COMP=3, WAIT=4, WRITE=5, DONE=6.
REQ-023 Start edge = start & !start_q; start_q registers start and resets to 0.
REQ-024 IDLE, start edge, 1<=sizes<=MAX_N -> latch n, clear err and both counters, go to LOAD_A.
REQ-025 IDLE, start edge, sizes=0 or sizes>MAX_N -> go to DONE with err=1; ren is never asserted.
REQ-026 LOAD_A lasts n*n cycles: ren=1, raddr=0, load_we=1.
REQ-027 In LOAD_A and LOAD_B, element k maps to row k/n, col k%n; load_addr = row*MAX_N+col; input_data_num increments each cycle.
REQ-028 LOAD_B lasts n*n cycles: ren=1, raddr=1, load_we=1, same address map.
REQ-029 COMP, output element (i,j), step k=0..n-1: one cycle each with mac_en=1, rd_addr_a=i*MAX_N+k, rd_addr_b=k*MAX_N+j.
REQ-030 mac_clr=1 only at k=0; mac_last=1 only at k=n-1; for n=1 both are set in the same cycle.
REQ-031 WAIT holds for WAIT_CYC cycles with no strobes.
REQ-032 WRITE lasts one cycle: wen=1, waddr=i*MAX_N+j, out_data_num increments.
REQ-033 After WRITE: go to COMP for the next (i,j) in row-major order, or to DONE after (n-1,n-1).
REQ-034 DONE lasts one cycle: finish=1, then IDLE.
REQ-035 Latency for a valid n: with the start edge sampled at cycle 0, finish is asserted at cycle 2n^2 + n^2(n+1+WAIT_CYC) + 1.
REQ-036 start is ignored outside IDLE; start held high through finish does not launch a new job; a new job needs start low for at least one cycle.
REQ-037 Counters, err and the latched n hold their values after DONE until the next accepted start.
REQ-038 All strobes (ren, load_we, mac_*, wen, finish) are 0 outside their states; raddr, the address outputs and waddr are 0 in IDLE.

Reset
REQ-039 rst=1 at a clock edge -> IDLE, all outputs 0, counters 0, err 0, start_q 0, in any state including mid-job.
REQ-040 An aborted job produces no finish and no further wen.
REQ-041 After rst deasserts, a start level already high counts as a rising edge.

Verification
REQ-042 n=2, start edge -> ren high for 8 cycles (raddr 0 for 4, then 1 for 4); 4 wen with waddr 0,1,6,7; finish at cycle 29; input_data_num=8; out_data_num=4.
REQ-043 n=1 -> mac_clr and mac_last coincide; single wen with waddr 0; finish at cycle 7.
REQ-044 n=6 -> 36 wen with waddr sequence 0..5,6..11,...,30..35; finish at cycle 397; at the last element, rd_addr_b steps 5,11,...,35.
REQ-045 sizes=0 or sizes=7 -> state goes 0,6,0; finish=1 with err=1; ren never asserted.
REQ-046 rst pulsed during COMP of n=3 -> next cycle state=0, all outputs 0; with start kept high, a clean job restarts and completes with 9 wen.
REQ-047 start held high across finish -> exactly one job; drop start for one cycle and raise it again -> a second job runs.
